// File: rtl/spi_slave_io_pkg.sv
// ============================================================================
// spi_slave_io_pkg : shared constants for the SPI slave i/o bridge
// Revision: 1.0
// ============================================================================
`default_nettype none

package spi_slave_io_pkg;
    localparam int unsigned BIT_CNT_W           = 3;
    localparam int unsigned SYNC_STAGES_DEFAULT = 2;
    localparam logic [7:0]  IDLE_BYTE_DEFAULT   = 8'h00;
endpackage

`default_nettype wire

// File: rtl/spi_in_sync.sv
// ============================================================================
// spi_in_sync : N-stage input synchronizer with rise/fall edge pulses
// Revision: 1.0
// ============================================================================
`default_nettype none

module spi_in_sync #(
    parameter int unsigned STAGES    = 2,
    parameter logic        RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] chain;
    logic              prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain <= {STAGES{RESET_VAL}};
            prev  <= RESET_VAL;
        end else begin
            chain <= {chain[STAGES-2:0], d};
            prev  <= chain[STAGES-1];
        end
    end

    assign q    = chain[STAGES-1];
    assign rise = q & ~prev;
    assign fall = ~q & prev;

endmodule

`default_nettype wire

// File: rtl/spi_slave_io.sv
// ============================================================================
// spi_slave_io : mode-0 byte SPI slave bridged to a register-style i/o port
// Revision: 1.0
// ============================================================================
`default_nettype none

module spi_slave_io
    import spi_slave_io_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEFAULT,
    parameter logic [7:0]  IDLE_BYTE   = IDLE_BYTE_DEFAULT
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_cs,
    input  logic [7:0] i_data,
    output logic [7:0] o_data,
    input  logic       i_we,
    input  logic       i_re,
    output logic       o_rx_error,
    output logic       o_rx_ready,
    output logic       o_tx_error,
    output logic       o_tx_ready,
    input  logic       i_spi_sck,
    input  logic       i_spi_cs_l,
    input  logic       i_spi_mosi,
    output logic       o_spi_miso
);

    logic sck_unused, sck_rise, sck_fall;
    logic cs_q, cs_rise, cs_fall;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic mosi_s;

    spi_in_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sck_sync (
        .clk(i_clk), .rst_n(i_rst_n), .d(i_spi_sck),
        .q(sck_unused), .rise(sck_rise), .fall(sck_fall)
    );

    spi_in_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs_sync (
        .clk(i_clk), .rst_n(i_rst_n), .d(i_spi_cs_l),
        .q(cs_q), .rise(cs_rise), .fall(cs_fall)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) mosi_sync <= '0;
        else          mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], i_spi_mosi};
    end
    assign mosi_s = mosi_sync[SYNC_STAGES-1];

    logic [BIT_CNT_W-1:0] bit_cnt;
    logic [7:0] rx_shift, tx_shift, tx_hold;
    logic tx_pending;
    logic rd_ack, wr_req, byte_done, boundary;

    assign rd_ack    = i_cs & i_re;
    assign wr_req    = i_cs & i_we;
    assign byte_done = ~cs_q & sck_rise & (&bit_cnt);
    // A byte slot begins at frame start and right after every completed byte.
    assign boundary  = cs_fall | byte_done;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            bit_cnt    <= '0;
            rx_shift   <= '0;
            tx_shift   <= '0;
            tx_hold    <= '0;
            tx_pending <= 1'b0;
            o_data     <= '0;
            o_rx_ready <= 1'b0;
            o_rx_error <= 1'b0;
            o_tx_error <= 1'b0;
        end else begin
            if (cs_q || cs_rise) begin
                bit_cnt  <= '0;
                rx_shift <= '0;
            end else if (sck_rise) begin
                rx_shift <= {rx_shift[6:0], mosi_s};
                bit_cnt  <= bit_cnt + 1'b1;
            end

            if (byte_done) begin
                o_data     <= {rx_shift[6:0], mosi_s};
                o_rx_ready <= 1'b1;
            end else if (rd_ack) begin
                o_rx_ready <= 1'b0;
            end

            if (rd_ack)
                o_rx_error <= 1'b0;
            else if (byte_done && o_rx_ready)
                o_rx_error <= 1'b1;

            if (boundary)
                tx_shift <= tx_pending ? tx_hold : IDLE_BYTE;
            else if (sck_fall && !cs_q && bit_cnt != '0)
                tx_shift <= {tx_shift[6:0], 1'b0};

            // Load-clear comes first so a write accepted this cycle survives it.
            if (boundary)
                tx_pending <= 1'b0;
            if (wr_req) begin
                if (!tx_pending) begin
                    tx_hold    <= i_data;
                    tx_pending <= 1'b1;
                    o_tx_error <= 1'b0;
                end else begin
                    o_tx_error <= 1'b1;
                end
            end
        end
    end

    assign o_tx_ready = ~tx_pending;
    assign o_spi_miso = tx_shift[7];

endmodule

`default_nettype wire

// File: tb/tb_spi_slave_io.sv
// ============================================================================
// tb_spi_slave_io : randomized self-checking bench with a byte-level model
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_spi_slave_io;

    localparam logic [7:0] IDLE = 8'hE7;
    localparam int H = 8;

    logic clk = 1'b0;
    logic rst_n, cs, we, re, sck, cs_l, mosi, miso;
    logic [7:0] din, dout;
    logic rx_err, rx_rdy, tx_err, tx_rdy;

    int vectors = 0;
    int errors  = 0;

    // Byte-level reference state
    logic [7:0] m_data, m_hold, m_slot;
    logic m_rx_ready, m_rx_err, m_tx_pend, m_tx_err;

    spi_slave_io #(.SYNC_STAGES(2), .IDLE_BYTE(IDLE)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_cs(cs), .i_data(din), .o_data(dout),
        .i_we(we), .i_re(re), .o_rx_error(rx_err), .o_rx_ready(rx_rdy),
        .o_tx_error(tx_err), .o_tx_ready(tx_rdy), .i_spi_sck(sck),
        .i_spi_cs_l(cs_l), .i_spi_mosi(mosi), .o_spi_miso(miso)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] dut_status();
        return {dout, rx_rdy, rx_err, tx_rdy, tx_err};
    endfunction

    function automatic logic [11:0] model_status();
        return {m_data, m_rx_ready, m_rx_err, ~m_tx_pend, m_tx_err};
    endfunction

    task automatic model_reset();
        m_data = 8'h00; m_hold = 8'h00; m_slot = 8'h00;
        m_rx_ready = 1'b0; m_rx_err = 1'b0; m_tx_pend = 1'b0; m_tx_err = 1'b0;
    endtask

    task automatic model_boundary();
        m_slot    = m_tx_pend ? m_hold : IDLE;
        m_tx_pend = 1'b0;
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic frame_start();
        cs_l = 1'b0;
        model_boundary();
        wait_clks(H);
    endtask

    task automatic frame_end();
        wait_clks(H);
        cs_l = 1'b1;
        wait_clks(H);
    endtask

    task automatic spi_xfer(input logic [7:0] mo, output logic [7:0] mi);
        for (int i = 7; i >= 0; i--) begin
            mosi = mo[i];
            wait_clks(H);
            mi[i] = miso;
            sck = 1'b1;
            wait_clks(H);
            sck = 1'b0;
        end
        if (m_rx_ready) m_rx_err = 1'b1;
        m_rx_ready = 1'b1;
        m_data     = mo;
        model_boundary();
    endtask

    task automatic do_write(input logic [7:0] b);
        @(negedge clk);
        cs = 1'b1; we = 1'b1; din = b;
        @(negedge clk);
        cs = 1'b0; we = 1'b0;
        if (m_tx_pend) m_tx_err = 1'b1;
        else begin m_hold = b; m_tx_pend = 1'b1; m_tx_err = 1'b0; end
    endtask

    task automatic do_ack(output logic [7:0] seen);
        @(negedge clk);
        cs = 1'b1; re = 1'b1;
        seen = dout;
        @(negedge clk);
        cs = 1'b0; re = 1'b0;
        m_rx_ready = 1'b0; m_rx_err = 1'b0;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0; sck = 1'b0; cs_l = 1'b1; mosi = 1'b0;
        cs = 1'b0; we = 1'b0; re = 1'b0; din = 8'h00;
        model_reset();
        wait_clks(3);
        rst_n = 1'b1;
        wait_clks(2);
    endtask

    task automatic test_reset();
        apply_reset();
        vectors++;
        if (dut_status() !== 12'b0000_0000_0010) begin
            errors++; $display("FAIL reset_status: got %h want %h", dut_status(), 12'h002);
        end
        vectors++;
        if (miso !== 1'b0) begin
            errors++; $display("FAIL reset_miso: got %b want 0", miso);
        end
    endtask

    task automatic test_single_rx();
        logic [7:0] mi, seen, exp_tx;
        frame_start();
        exp_tx = m_slot;
        spi_xfer(8'h81, mi);
        frame_end();
        vectors++;
        if (mi !== exp_tx) begin errors++; $display("FAIL single_miso: got %h want %h", mi, exp_tx); end
        vectors++;
        if (dut_status() !== model_status()) begin
            errors++; $display("FAIL single_status: got %h want %h", dut_status(), model_status());
        end
        do_ack(seen);
        vectors++;
        if (seen !== 8'h81) begin errors++; $display("FAIL single_ack_data: got %h want 81", seen); end
        vectors++;
        if (dut_status() !== model_status()) begin
            errors++; $display("FAIL single_after_ack: got %h want %h", dut_status(), model_status());
        end
    endtask

    task automatic test_multi_rx();
        logic [7:0] bytes [3] = '{8'h82, 8'h01, 8'h23};
        logic [7:0] mi, seen;
        frame_start();
        for (int k = 0; k < 3; k++) begin
            spi_xfer(bytes[k], mi);
            do_ack(seen);
            vectors++;
            if (seen !== bytes[k]) begin
                errors++; $display("FAIL multi_data[%0d]: got %h want %h", k, seen, bytes[k]);
            end
            vectors++;
            if (dut_status() !== model_status()) begin
                errors++; $display("FAIL multi_status[%0d]: got %h want %h", k, dut_status(), model_status());
            end
        end
        frame_end();
    endtask

    task automatic test_overrun();
        logic [7:0] mi, seen;
        frame_start();
        spi_xfer(8'hAA, mi);
        spi_xfer(8'h55, mi);
        frame_end();
        vectors++;
        if (dut_status() !== model_status() || rx_err !== 1'b1) begin
            errors++; $display("FAIL overrun_status: got %h want %h", dut_status(), model_status());
        end
        do_ack(seen);
        vectors++;
        if (dut_status() !== model_status()) begin
            errors++; $display("FAIL overrun_clear: got %h want %h", dut_status(), model_status());
        end
    endtask

    task automatic test_tx_path();
        logic [7:0] mi, seen, exp_tx;
        frame_start();
        spi_xfer(8'h00, mi);
        do_write(8'h5A);
        vectors++;
        if (tx_rdy !== 1'b0) begin errors++; $display("FAIL tx_ready_after_write: got %b want 0", tx_rdy); end
        exp_tx = m_slot;
        spi_xfer(8'h3C, mi);
        vectors++;
        if (mi !== exp_tx || mi !== IDLE) begin
            errors++; $display("FAIL tx_byte1: got %h want %h", mi, IDLE);
        end
        vectors++;
        if (dut_status() !== model_status()) begin
            errors++; $display("FAIL tx_status_byte1: got %h want %h", dut_status(), model_status());
        end
        exp_tx = m_slot;
        spi_xfer(8'hC0, mi);
        vectors++;
        if (mi !== exp_tx || mi !== 8'h5A) begin
            errors++; $display("FAIL tx_byte2: got %h want 5a", mi);
        end
        frame_end();
        do_ack(seen);
    endtask

    task automatic test_tx_error();
        logic [7:0] mi, seen, exp_tx;
        do_write(8'h11);
        do_write(8'h22);
        vectors++;
        if (dut_status() !== model_status() || tx_err !== 1'b1) begin
            errors++; $display("FAIL tx_error_set: got %h want %h", dut_status(), model_status());
        end
        frame_start();
        exp_tx = m_slot;
        spi_xfer(8'h99, mi);
        frame_end();
        vectors++;
        if (mi !== exp_tx || mi !== 8'h11) begin
            errors++; $display("FAIL tx_error_byte: got %h want 11", mi);
        end
        do_write(8'h33);
        vectors++;
        if (dut_status() !== model_status()) begin
            errors++; $display("FAIL tx_error_clear: got %h want %h", dut_status(), model_status());
        end
        do_ack(seen);
        frame_start();
        spi_xfer(8'h00, mi);
        frame_end();
        do_ack(seen);
    endtask

    task automatic test_partial();
        logic [7:0] mi;
        frame_start();
        for (int i = 0; i < 3; i++) begin
            mosi = ~mosi;
            wait_clks(H); sck = 1'b1; wait_clks(H); sck = 1'b0;
        end
        frame_end();
        frame_start();
        spi_xfer(8'hC3, mi);
        frame_end();
        vectors++;
        if (dut_status() !== model_status() || dout !== 8'hC3) begin
            errors++; $display("FAIL partial_then_c3: got %h want %h", dut_status(), model_status());
        end
    endtask

    task automatic test_random();
        logic [7:0] mi, seen, b, exp_tx;
        int nb, op;
        for (int f = 0; f < 12; f++) begin
            if ($urandom_range(0, 1) == 1) do_write(8'($urandom));
            frame_start();
            nb = $urandom_range(1, 3);
            for (int k = 0; k < nb; k++) begin
                exp_tx = m_slot;
                b = 8'($urandom);
                spi_xfer(b, mi);
                vectors++;
                if (mi !== exp_tx) begin
                    errors++; $display("FAIL rand_miso[%0d.%0d]: got %h want %h", f, k, mi, exp_tx);
                end
                vectors++;
                if (dut_status() !== model_status()) begin
                    errors++; $display("FAIL rand_status[%0d.%0d]: got %h want %h", f, k, dut_status(), model_status());
                end
                op = $urandom_range(0, 3);
                if (op == 1 || op == 3) do_write(8'($urandom));
                if (op == 3) do_write(8'($urandom));
                if (op >= 2) begin
                    do_ack(seen);
                    vectors++;
                    if (seen !== b) begin
                        errors++; $display("FAIL rand_ack[%0d.%0d]: got %h want %h", f, k, seen, b);
                    end
                end
            end
            frame_end();
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] mi, exp_tx;
        do_write(8'h7E);
        frame_start();
        for (int i = 0; i < 4; i++) begin
            mosi = 1'b1;
            wait_clks(H); sck = 1'b1; wait_clks(H);
            if (i < 3) sck = 1'b0;
        end
        rst_n = 1'b0;
        #2;
        vectors++;
        if (dut_status() !== 12'h002 || miso !== 1'b0) begin
            errors++; $display("FAIL reset_mid: got %h/%b want 002/0", dut_status(), miso);
        end
        sck = 1'b0; cs_l = 1'b1; mosi = 1'b0;
        model_reset();
        wait_clks(3);
        rst_n = 1'b1;
        wait_clks(3);
        frame_start();
        exp_tx = m_slot;
        spi_xfer(8'h6D, mi);
        frame_end();
        vectors++;
        if (dut_status() !== model_status() || mi !== exp_tx) begin
            errors++; $display("FAIL after_reset: got %h/%h want %h/%h", dut_status(), mi, model_status(), exp_tx);
        end
    endtask

    initial begin
        test_reset();
        test_single_rx();
        test_multi_rx();
        test_overrun();
        test_tx_path();
        test_tx_error();
        test_partial();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

`default_nettype wire
